// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: intersection light sequencer that starts a shared countdown timer on every state entry.
// Optional pedestrian phase is compiled in with `define WALK_PHASE_EN.
module traffic_light_fsm #(
  parameter int unsigned SEL_W = 2
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             Sensor,
  input  logic             Walk_Request,
  input  logic             expired,
  output logic             start_timer,
  output logic [SEL_W-1:0] Interval,
  output logic [2:0]       Main_Lights,
  output logic [2:0]       Side_Lights,
  output logic             Walk
);

  localparam int unsigned GUARD_W = 2;
  localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(2);

  localparam logic [1:0] CODE_BASE = 2'b00;
  localparam logic [1:0] CODE_EXT  = 2'b01;
  localparam logic [1:0] CODE_YEL  = 2'b10;
`ifdef WALK_PHASE_EN
  localparam logic [1:0] CODE_WALK = 2'b11;
`endif

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [2:0] {
    MAIN_GRN_BASE,
    MAIN_GRN_EXT,
    MAIN_YEL,
`ifdef WALK_PHASE_EN
    WALK,
`endif
    SIDE_GRN_BASE,
    SIDE_GRN_EXT,
    SIDE_YEL
  } state_t;

  state_t             state_q, state_d;
  logic               start_pending_q, start_pending_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic               start_d;
  logic [SEL_W-1:0]   interval_d;
  logic [2:0]         main_d, side_d;
  logic               walk_d;
  logic               qualified_c;

`ifdef WALK_PHASE_EN
  logic walk_latch_q, walk_latch_d;
`else
  logic unused_walk_request;
  assign unused_walk_request = Walk_Request;
`endif

  // State, handshake bookkeeping and registered outputs
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q         <= MAIN_GRN_BASE;
      start_pending_q <= 1'b1;
      guard_q         <= '0;
      start_timer     <= 1'b0;
      Interval        <= '0;
      Main_Lights     <= LAMP_G;
      Side_Lights     <= LAMP_R;
      Walk            <= 1'b0;
`ifdef WALK_PHASE_EN
      walk_latch_q    <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      start_pending_q <= start_pending_d;
      guard_q         <= guard_d;
      start_timer     <= start_d;
      Interval        <= interval_d;
      Main_Lights     <= main_d;
      Side_Lights     <= side_d;
      Walk            <= walk_d;
`ifdef WALK_PHASE_EN
      walk_latch_q    <= walk_latch_d;
`endif
    end
  end

  // Next state, timer restart and light decode of the next state
  always_comb begin
    state_d         = state_q;
    start_d         = 1'b0;
    start_pending_d = start_pending_q;
    guard_d         = (guard_q != '0) ? guard_q - GUARD_W'(1) : guard_q;
    interval_d      = '0;
    main_d          = LAMP_R;
    side_d          = LAMP_R;
    walk_d          = 1'b0;
`ifdef WALK_PHASE_EN
    walk_latch_d    = walk_latch_q | Walk_Request;
`endif
    // expired is only meaningful once the timer has loaded the current interval
    qualified_c = expired && !start_pending_q && (guard_q == '0);

    if (qualified_c) begin
      case (state_q)
        MAIN_GRN_BASE: state_d = Sensor ? MAIN_YEL : MAIN_GRN_EXT;
        MAIN_GRN_EXT:  state_d = MAIN_YEL;
`ifdef WALK_PHASE_EN
        MAIN_YEL: begin
          if (walk_latch_q) begin
            state_d      = WALK;
            walk_latch_d = 1'b0;
          end else begin
            state_d = SIDE_GRN_BASE;
          end
        end
        WALK:          state_d = SIDE_GRN_BASE;
`else
        MAIN_YEL:      state_d = SIDE_GRN_BASE;
`endif
        SIDE_GRN_BASE: state_d = Sensor ? SIDE_GRN_EXT : SIDE_YEL;
        SIDE_GRN_EXT:  state_d = SIDE_YEL;
        SIDE_YEL:      state_d = MAIN_GRN_BASE;
        default:       state_d = MAIN_GRN_BASE;
      endcase
    end

    if (qualified_c || start_pending_q) begin
      start_d         = 1'b1;
      guard_d         = GUARD_INIT;
      start_pending_d = 1'b0;
    end

    case (state_d)
      MAIN_GRN_BASE: begin interval_d = SEL_W'(CODE_BASE); main_d = LAMP_G; end
      MAIN_GRN_EXT:  begin interval_d = SEL_W'(CODE_EXT);  main_d = LAMP_G; end
      MAIN_YEL:      begin interval_d = SEL_W'(CODE_YEL);  main_d = LAMP_Y; end
`ifdef WALK_PHASE_EN
      WALK:          begin interval_d = SEL_W'(CODE_WALK); walk_d = 1'b1; end
`endif
      SIDE_GRN_BASE: begin interval_d = SEL_W'(CODE_BASE); side_d = LAMP_G; end
      SIDE_GRN_EXT:  begin interval_d = SEL_W'(CODE_EXT);  side_d = LAMP_G; end
      SIDE_YEL:      begin interval_d = SEL_W'(CODE_YEL);  side_d = LAMP_Y; end
      default:       begin interval_d = '0; end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb_traffic_light_fsm: randomized and timer-driven stimulus checked against a table-based phase model.
// Honours `define WALK_PHASE_EN the same way as the design.
module tb_traffic_light_fsm;

  logic       clk;
  logic       Reset_n;
  logic       Sensor;
  logic       Walk_Request;
  logic       expired;
  logic       start_timer;
  logic [1:0] Interval;
  logic [2:0] Main_Lights;
  logic [2:0] Side_Lights;
  logic       Walk;

  traffic_light_fsm #(.SEL_W(2)) dut (
    .clk          (clk),
    .Reset_n      (Reset_n),
    .Sensor       (Sensor),
    .Walk_Request (Walk_Request),
    .expired      (expired),
    .start_timer  (start_timer),
    .Interval     (Interval),
    .Main_Lights  (Main_Lights),
    .Side_Lights  (Side_Lights),
    .Walk         (Walk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef WALK_PHASE_EN
  localparam bit WALK_EN = 1'b1;
`else
  localparam bit WALK_EN = 1'b0;
`endif

  // Phases 0..6: main green base/ext, main yellow, walk, side green base/ext, side yellow
  int         code_tab [7] = '{0, 1, 2, 3, 0, 1, 2};
  logic [2:0] main_tab [7] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] side_tab [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
  int         dur_tab  [4] = '{6, 3, 2, 3};

  int total = 0;
  int bad   = 0;

  int m_phase;
  int m_age;
  bit m_pending;
  bit m_wlatch;
  bit m_start;
  int t_cnt;
  bit t_load;

  logic [1:0] obs[$];
  int         exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int next_phase(input int p, input bit s, input bit wl);
    case (p)
      0:       return s ? 2 : 1;
      1:       return 2;
      2:       return wl ? 3 : 4;
      3:       return 4;
      4:       return s ? 5 : 6;
      5:       return 6;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase   = 0;
    m_age     = 0;
    m_pending = 1'b1;
    m_wlatch  = 1'b0;
    m_start   = 1'b0;
    t_cnt     = 0;
    t_load    = 1'b0;
  endtask

  // One clock of the reference: what the DUT must show after the coming edge
  task automatic model_advance(input bit s, input bit w, input bit e);
    int nxt;
    if (m_pending) begin
      m_pending = 1'b0;
      m_start   = 1'b1;
      m_age     = 0;
      m_wlatch  = m_wlatch | (w & WALK_EN);
    end else if (e && m_age >= 2) begin
      nxt = next_phase(m_phase, s, WALK_EN && m_wlatch);
      if (nxt == 3) m_wlatch = 1'b0;
      else          m_wlatch = m_wlatch | (w & WALK_EN);
      m_phase = nxt;
      m_start = 1'b1;
      m_age   = 0;
    end else begin
      m_start  = 1'b0;
      m_age    = m_age + 1;
      m_wlatch = m_wlatch | (w & WALK_EN);
    end
  endtask

  task automatic compare_all();
    logic safe;
    check("start_timer", start_timer, m_start);
    check("interval", Interval, code_tab[m_phase]);
    check("main", Main_Lights, main_tab[m_phase]);
    check("side", Side_Lights, side_tab[m_phase]);
    check("walk", Walk, (m_phase == 3));
    safe = ((Main_Lights == 3'b100) || (Side_Lights == 3'b100)) &&
           (!Walk || (Main_Lights == 3'b100 && Side_Lights == 3'b100)) &&
           $onehot(Main_Lights) && $onehot(Side_Lights);
    check("safety", safe, 1);
  endtask

  task automatic step(input bit s, input bit w, input bit e);
    Sensor       = s;
    Walk_Request = w;
    expired      = e;
    model_advance(s, w, e);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    expired = 1'b1;
    #2;
    check("rst_main", Main_Lights, 3'b001);
    check("rst_side", Side_Lights, 3'b100);
    check("rst_walk", Walk, 0);
    check("rst_start", start_timer, 0);
    check("rst_interval", Interval, 0);
    @(posedge clk);
    #1;
    Reset_n = 1'b1;
    expired = 1'b0;
    model_reset();
  endtask

  // Drive expired from a countdown timer model; collect DUT intervals at each start pulse
  task automatic run_timed(input bit s, input bit w_hold, input int w_at, input int n);
    int cyc;
    int starts;
    bit e;
    cyc    = 0;
    starts = 0;
    obs.delete();
    while (starts < n && cyc < 400) begin
      e = 1'b0;
      if (t_load) begin
        t_cnt  = dur_tab[code_tab[m_phase]];
        t_load = 1'b0;
      end else if (t_cnt > 0 && (cyc % 4) == 0) begin
        t_cnt = t_cnt - 1;
        if (t_cnt == 0) e = 1'b1;
      end
      if (m_start) t_load = 1'b1;
      step(s, w_hold || (cyc == w_at), e);
      if (start_timer === 1'b1) obs.push_back(Interval);
      if (m_start) starts++;
      cyc++;
    end
    check("run_done", (starts >= n), 1);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs.size()) check(tag, obs[i], exp_q[i]);
    end
  endtask

  initial begin
    Reset_n      = 1'b1;
    Sensor       = 1'b0;
    Walk_Request = 1'b0;
    expired      = 1'b0;
    model_reset();
    #1;
    do_reset();

    // Quiet side street
    run_timed(1'b0, 1'b0, -1, 6);
    exp_q = '{0, 1, 2, 0, 2, 0};
    check_seq("seq_no_sensor");

    // Side traffic present throughout
    do_reset();
    run_timed(1'b1, 1'b0, -1, 6);
    exp_q = '{0, 2, 0, 1, 2, 0};
    check_seq("seq_sensor");

`ifdef WALK_PHASE_EN
    do_reset();
    run_timed(1'b0, 1'b0, 5, 10);
    exp_q = '{0, 1, 2, 3, 0, 2, 0, 1, 2, 0};
    check_seq("seq_walk");
`else
    do_reset();
    run_timed(1'b0, 1'b1, -1, 6);
    exp_q = '{0, 1, 2, 0, 2, 0};
    check_seq("seq_walk_ignored");
    foreach (obs[i]) check("no_walk_code", (obs[i] == 2'b11), 0);
`endif

    // Expired inside the start guard must be ignored
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    check("guard_start", start_timer, 1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("guard_hold_main", Main_Lights, 3'b001);
    check("guard_hold_start", start_timer, 0);
    step(1'b0, 1'b0, 1'b1);
    check("guard_fire_start", start_timer, 1);
    check("guard_fire_code", Interval, 1);

    // Reset in the middle of side green extension, with a walk request pending
    do_reset();
    run_timed(1'b1, 1'b0, -1, 4);
    check("mid_side_green", Side_Lights, 3'b001);
    step(1'b1, 1'b1, 1'b0);
    do_reset();
    run_timed(1'b0, 1'b0, -1, 4);
    exp_q = '{0, 1, 2, 0};
    check_seq("seq_after_reset");

    // Random sensor, walk and expired traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
